// File: rtl/cdc_pkg.sv
// Shared types for the async FIFO read-side consumer.
// Imported by the reader top level and its prefetch buffer.
package cdc_pkg;

  typedef enum logic [0:0] {
    RUN,
    FLUSH
  } fifo_reader_state_e;

  localparam int FIFO_READ_LATENCY = 1;
  localparam int BUF_DEPTH         = 3;

  function automatic logic [1:0] ptr_inc(
    input logic [1:0] p
  );
    return (p == 2'(BUF_DEPTH - 1)) ? 2'd0 : p + 2'd1;
  endfunction

endpackage

// File: rtl/cdc_fifo_reader_buf.sv
// Three-entry register FIFO used as the reader prefetch buffer.
// Clear empties it; a clear wins over a push in the same cycle.
module cdc_fifo_reader_buf
  import cdc_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [1:0]            occ
);

  logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
  logic [1:0]            wr_ptr;
  logic [1:0]            rd_ptr;

  always_ff @(posedge clk_i) begin
    if (rst_i || clear) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      occ    <= 2'd0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      occ <= occ + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk_i) begin
    if (push && !clear) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/cdc_fifo_reader.sv
// Async FIFO read-side consumer: prefetches words and presents
// a valid/ready stream, with a flush mode that discards contents.
module cdc_fifo_reader
  import cdc_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  output logic                  fifo_rd_en_o,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data_i,
  input  logic                  fifo_empty_i,
  output logic                  m_valid_o,
  output logic [DATA_WIDTH-1:0] m_data_o,
  input  logic                  m_ready_i,
  input  logic                  flush_i,
  output logic                  flush_busy_o,
  output logic [CNT_WIDTH-1:0]  beat_count_o
);

  fifo_reader_state_e state;
  fifo_reader_state_e state_nxt;

  logic       inflight;
  logic [1:0] occ;
  logic       pop;
  logic       push;
  logic       go_flush;
  logic [2:0] committed;

  // Words already held plus the one on its way back from the FIFO.
  assign committed = {1'b0, occ} + {2'b0, inflight};

  always_comb begin
    state_nxt    = state;
    fifo_rd_en_o = 1'b0;
    m_valid_o    = 1'b0;
    flush_busy_o = 1'b0;
    go_flush     = 1'b0;
    unique case (state)
      RUN: begin
        m_valid_o    = (occ != 2'd0);
        fifo_rd_en_o = !fifo_empty_i && (committed <= 3'd2);
        if (flush_i) begin
          go_flush  = 1'b1;
          state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        flush_busy_o = 1'b1;
        fifo_rd_en_o = !fifo_empty_i;
        if (fifo_empty_i && !inflight) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  assign pop  = m_valid_o && m_ready_i;
  assign push = inflight && (state == RUN) && !go_flush;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= RUN;
      inflight     <= 1'b0;
      beat_count_o <= '0;
    end else begin
      state    <= state_nxt;
      inflight <= fifo_rd_en_o;
      if (pop) beat_count_o <= beat_count_o + 1'b1;
    end
  end

  cdc_fifo_reader_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_buf (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (push),
    .pop   (pop),
    .clear (go_flush),
    .wdata (fifo_rd_data_i),
    .rdata (m_data_o),
    .occ   (occ)
  );

endmodule

// File: tb/tb_cdc_fifo_reader.sv
// Scoreboard bench for cdc_fifo_reader with a behavioural FIFO
// model, random backpressure and flush/reset scenarios.
module tb_cdc_fifo_reader;

  localparam int DW = 16;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          fifo_rd_en_o;
  logic [DW-1:0] fifo_rd_data_i;
  logic          fifo_empty_i;
  logic          m_valid_o;
  logic [DW-1:0] m_data_o;
  logic          m_ready_i;
  logic          flush_i;
  logic          flush_busy_o;
  logic [CW-1:0] beat_count_o;

  always #5 clk = ~clk;

  cdc_fifo_reader #(
    .DATA_WIDTH(DW),
    .CNT_WIDTH (CW)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .fifo_rd_en_o  (fifo_rd_en_o),
    .fifo_rd_data_i(fifo_rd_data_i),
    .fifo_empty_i  (fifo_empty_i),
    .m_valid_o     (m_valid_o),
    .m_data_o      (m_data_o),
    .m_ready_i     (m_ready_i),
    .flush_i       (flush_i),
    .flush_busy_o  (flush_busy_o),
    .beat_count_o  (beat_count_o)
  );

  logic [DW-1:0] fifo_q [$];
  logic [DW-1:0] exp_q  [$];
  int            fifo_cnt = 0;
  logic          stall = 1'b0;
  int            n_cmp = 0;
  int            n_err = 0;
  int            rd_pulses = 0;

  assign fifo_empty_i = (fifo_cnt == 0) || stall;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  // Source FIFO: one-cycle read latency, garbage when idle.
  always @(posedge clk) begin
    if (fifo_rd_en_o && fifo_cnt > 0) begin
      fifo_rd_data_i <= fifo_q.pop_front();
      fifo_cnt--;
    end else begin
      fifo_rd_data_i <= 16'($urandom);
    end
  end

  logic          hold_pend = 1'b0;
  logic [DW-1:0] hold_data;
  logic          flush_prev = 1'b0;

  // Monitor: scoreboard pop, stability and underflow checks.
  always @(negedge clk) begin
    if (rst_i) begin
      hold_pend  = 1'b0;
      flush_prev = 1'b0;
    end else begin
      if (fifo_rd_en_o) begin
        rd_pulses++;
        chk("no_underflow", 32'(fifo_empty_i), 32'd0);
      end
      if (hold_pend && !flush_prev) begin
        chk("hold_valid", 32'(m_valid_o), 32'd1);
        chk("hold_data", 32'(m_data_o), 32'(hold_data));
      end
      if (m_valid_o && m_ready_i) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_beat: got %0h, required none",
                   m_data_o);
        end else begin
          chk("beat_data", 32'(m_data_o), 32'(exp_q.pop_front()));
        end
      end
      hold_pend  = m_valid_o && !m_ready_i;
      hold_data  = m_data_o;
      flush_prev = flush_i;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_raw(input logic [DW-1:0] w);
    fifo_q.push_back(w);
    fifo_cnt++;
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    push_raw(w);
    exp_q.push_back(w);
  endtask

  task automatic do_reset();
    rst_i     = 1'b1;
    flush_i   = 1'b0;
    m_ready_i = 1'b0;
    stall     = 1'b0;
    exp_q.delete();
    step();
    step();
    rst_i     = 1'b0;
    rd_pulses = 0;
  endtask

  task automatic drain(input int max);
    for (int i = 0; i < max && exp_q.size() != 0; i++) step();
    chk("drain_left", 32'(exp_q.size()), 32'd0);
    step();
    step();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1);
  end

  initial begin
    int sent;
    rst_i     = 1'b1;
    flush_i   = 1'b0;
    m_ready_i = 1'b0;
    step();
    step();
    rst_i = 1'b0;
    @(negedge clk);
    chk("rst_valid", 32'(m_valid_o), 32'd0);
    chk("rst_rd_en", 32'(fifo_rd_en_o), 32'd0);
    chk("rst_busy", 32'(flush_busy_o), 32'd0);
    chk("rst_count", 32'(beat_count_o), 32'd0);

    // Streaming with full throughput and two-cycle latency.
    do_reset();
    m_ready_i = 1'b1;
    stall     = 1'b1;
    for (int i = 1; i <= 8; i++) push_word(16'(i));
    step();
    stall = 1'b0;
    @(negedge clk);
    chk("lat_rd_en", 32'(fifo_rd_en_o), 32'd1);
    chk("lat_valid0", 32'(m_valid_o), 32'd0);
    @(negedge clk);
    chk("lat_valid1", 32'(m_valid_o), 32'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("stream_nobubble", 32'(m_valid_o), 32'd1);
    end
    @(negedge clk);
    chk("stream_count", 32'(beat_count_o), 32'd8);
    chk("stream_idle", 32'(m_valid_o), 32'd0);

    // Backpressure: only three reads go out while stalled.
    do_reset();
    for (int i = 1; i <= 8; i++) push_word(16'(i));
    repeat (10) step();
    chk("bp_reads", 32'(rd_pulses), 32'd3);
    chk("bp_valid", 32'(m_valid_o), 32'd1);
    chk("bp_data", 32'(m_data_o), 32'h0001);
    m_ready_i = 1'b1;
    drain(50);
    chk("bp_count", 32'(beat_count_o), 32'd8);

    // Random ready and FIFO empty toggling.
    do_reset();
    sent = 0;
    for (int c = 0; c < 5000 && sent < 100; c++) begin
      m_ready_i = 1'($urandom % 2);
      stall     = ($urandom % 3) == 0;
      if ($urandom % 2 == 1) begin
        push_word(16'($urandom));
        sent++;
      end
      step();
    end
    chk("rand_sent", 32'(sent), 32'd100);
    stall     = 1'b0;
    m_ready_i = 1'b1;
    drain(400);
    chk("rand_count", 32'(beat_count_o), 32'(CW'(100)));

    // Flush after two beats discards the other eight words.
    do_reset();
    stall = 1'b1;
    for (int i = 1; i <= 10; i++) push_word(16'(16'h0100 + i));
    step();
    stall = 1'b0;
    repeat (6) step();
    m_ready_i = 1'b1;
    step();
    step();
    m_ready_i = 1'b0;
    flush_i   = 1'b1;
    chk("fl_pending", 32'(exp_q.size()), 32'd8);
    exp_q.delete();
    step();
    flush_i = 1'b0;
    chk("fl_valid", 32'(m_valid_o), 32'd0);
    chk("fl_busy", 32'(flush_busy_o), 32'd1);
    m_ready_i = 1'b1;
    for (int i = 0; i < 50 && flush_busy_o; i++) step();
    chk("fl_done", 32'(flush_busy_o), 32'd0);
    chk("fl_drained", 32'(fifo_cnt), 32'd0);
    chk("fl_count", 32'(beat_count_o), 32'd2);
    push_word(16'hABCD);
    drain(20);
    chk("fl_after", 32'(beat_count_o), 32'd3);

    // Counter wraps at 2^CW.
    do_reset();
    m_ready_i = 1'b1;
    for (int i = 0; i < 18; i++) push_word(16'(16'h0200 + i));
    drain(60);
    chk("wrap_count", 32'(beat_count_o), 32'd2);

    // Reset mid-stream with a read in flight.
    do_reset();
    push_word(16'h00A1);
    push_word(16'h00A2);
    repeat (6) step();
    chk("mr_valid", 32'(m_valid_o), 32'd1);
    chk("mr_data", 32'(m_data_o), 32'h00A1);
    push_raw(16'hDEAD);
    @(negedge clk);
    chk("mr_rd_en", 32'(fifo_rd_en_o), 32'd1);
    step();
    rst_i = 1'b1;
    exp_q.delete();
    step();
    step();
    rst_i = 1'b0;
    @(negedge clk);
    chk("mr_rst_valid", 32'(m_valid_o), 32'd0);
    chk("mr_rst_rd_en", 32'(fifo_rd_en_o), 32'd0);
    chk("mr_rst_busy", 32'(flush_busy_o), 32'd0);
    chk("mr_rst_count", 32'(beat_count_o), 32'd0);
    m_ready_i = 1'b1;
    repeat (8) step();
    chk("mr_no_data", 32'(m_valid_o), 32'd0);
    chk("mr_count", 32'(beat_count_o), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
